// File: rtl/control_unit.sv
// Instruction sequencer: fetches mem[PC], decodes it into datapath controls and
// retires one instruction per FETCH_WAIT+1 cycles, with flag latches and halt handling.
module control_unit #(
    parameter int FETCH_WAIT      = 1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [15:0] current_instruction,
    input  logic [15:0] signflag,
    input  logic [15:0] zeroflag,
    input  logic [15:0] errorbit,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [3:0]  alu_out_select,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic [3:0]  vga_color_select,
    output logic [3:0]  vga_coord_select,
    output logic        vga_plot,
    output logic        halted,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic        inc;
        logic [3:0]  op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic        a_src;
        logic        b_src;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [3:0]  out_sel;
        logic [1:0]  load_src;
        logic        store;
        logic [3:0]  color_sel;
        logic [3:0]  coord_sel;
        logic        plot;
    } ctrl_t;

    localparam logic [2:0] LAST_FETCH = 3'(FETCH_WAIT - 1);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [15:0] ir_q;
    logic        z_q;
    logic        n_q;
    logic        halted_q;
    logic        illegal_q;
    logic [15:0] instr_count_q;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_d;

    logic [3:0]  op_s;
    logic [3:0]  rd_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [7:0]  imm_s;
    logic [3:0]  ir_op_s;
    logic        ir_halt_s;
    logic        ir_illegal_s;
    logic        ir_sets_flags_s;
    logic        unused_s;

    assign op_s  = current_instruction[15:12];
    assign rd_s  = current_instruction[11:8];
    assign ra_s  = current_instruction[7:4];
    assign rb_s  = current_instruction[3:0];
    assign imm_s = current_instruction[7:0];

    assign ir_op_s         = ir_q[15:12];
    assign ir_illegal_s    = HALT_ON_ILLEGAL && (ir_op_s == 4'hD);
    assign ir_halt_s       = (ir_op_s == 4'hF) || ir_illegal_s;
    assign ir_sets_flags_s = (ir_op_s >= 4'h1) && (ir_op_s <= 4'h6);

    assign unused_s = ^{signflag[15:1], zeroflag[15:1], errorbit[15:1]};

    // Decode the fetched word into the control set that EXEC will present.
    always_comb begin
        ctrl_d     = '0;
        ctrl_d.inc = 1'b1;
        case (op_s)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                ctrl_d.op       = op_s;
                ctrl_d.a_sel    = ra_s;
                ctrl_d.b_sel    = rb_s;
                ctrl_d.out_sel  = rd_s;
                ctrl_d.load_src = 2'b01;
            end
            4'h6: begin
                ctrl_d.op       = 4'h1;
                ctrl_d.a_sel    = rd_s;
                ctrl_d.b_src    = 1'b1;
                ctrl_d.b_alt    = {{8{imm_s[7]}}, imm_s};
                ctrl_d.out_sel  = rd_s;
                ctrl_d.load_src = 2'b01;
            end
            4'h7: begin
                ctrl_d.a_src    = 1'b1;
                ctrl_d.a_alt    = {8'h00, imm_s};
                ctrl_d.out_sel  = rd_s;
                ctrl_d.load_src = 2'b01;
            end
            4'h8: begin
                ctrl_d.a_sel    = ra_s;
                ctrl_d.out_sel  = rd_s;
                ctrl_d.load_src = 2'b10;
            end
            4'h9: begin
                ctrl_d.a_sel   = ra_s;
                ctrl_d.out_sel = rd_s;
                ctrl_d.store   = 1'b1;
            end
            4'hA: begin
                ctrl_d.a_sel    = ra_s;
                ctrl_d.load_src = 2'b01;
            end
            4'hB: begin
                if (z_q) begin
                    ctrl_d.a_sel    = ra_s;
                    ctrl_d.load_src = 2'b01;
                end else begin
                    ctrl_d.inc = 1'b1;
                end
            end
            4'hC: begin
                if (n_q) begin
                    ctrl_d.a_sel    = ra_s;
                    ctrl_d.load_src = 2'b01;
                end else begin
                    ctrl_d.inc = 1'b1;
                end
            end
            4'hD: begin
                if (HALT_ON_ILLEGAL) begin
                    ctrl_d.inc = 1'b0;
                end else begin
                    ctrl_d.inc = 1'b1;
                end
            end
            4'hE: begin
                ctrl_d.color_sel = rd_s;
                ctrl_d.coord_sel = ra_s;
                ctrl_d.plot      = 1'b1;
            end
            4'hF: ctrl_d.inc = 1'b0;
            default: ctrl_d.inc = 1'b1;
        endcase
        // A register write to r0 is a PC write, so the PC must not also advance.
        ctrl_d.inc = ctrl_d.inc & ~((ctrl_d.load_src != 2'b00) && (ctrl_d.out_sel == 4'h0));
    end

    // Sequencer FSM with registered controls, flag latches and retire counter.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            ir_q          <= 16'h0000;
            z_q           <= 1'b0;
            n_q           <= 1'b0;
            halted_q      <= 1'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= 16'h0000;
            ctrl_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ctrl_q <= '0;
                    cnt_q  <= 3'd0;
                    if (run) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (cnt_q == LAST_FETCH) begin
                        ir_q    <= current_instruction;
                        ctrl_q  <= ctrl_d;
                        cnt_q   <= 3'd0;
                        state_q <= EXEC;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                EXEC: begin
                    ctrl_q        <= '0;
                    cnt_q         <= 3'd0;
                    instr_count_q <= instr_count_q + 16'd1;
                    if (ir_sets_flags_s) begin
                        z_q <= zeroflag[0];
                        n_q <= signflag[0];
                    end
                    if (ir_halt_s || errorbit[0]) begin
                        state_q   <= HALT;
                        halted_q  <= 1'b1;
                        illegal_q <= illegal_q | ir_illegal_s;
                    end else if (run) begin
                        state_q <= FETCH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HALT: begin
                    ctrl_q   <= '0;
                    halted_q <= 1'b1;
                end
                default: begin
                    ctrl_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign program_counter_increment = ctrl_q.inc;
    assign alu_op                    = ctrl_q.op;
    assign alu_a_select              = ctrl_q.a_sel;
    assign alu_b_select              = ctrl_q.b_sel;
    assign alu_a_source              = ctrl_q.a_src;
    assign alu_b_source              = ctrl_q.b_src;
    assign alu_a_altern              = ctrl_q.a_alt;
    assign alu_b_altern              = ctrl_q.b_alt;
    assign alu_out_select            = ctrl_q.out_sel;
    assign alu_load_src              = ctrl_q.load_src;
    assign alu_store_to_mem          = ctrl_q.store;
    assign alu_store_to_stk          = 1'b0;
    assign vga_color_select          = ctrl_q.color_sel;
    assign vga_coord_select          = ctrl_q.coord_sel;
    assign vga_plot                  = ctrl_q.plot;
    assign halted                    = halted_q;
    assign illegal_op                = illegal_q;
    assign instr_count               = instr_count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one task per scenario, hand-computed expectations.
module tb_control_unit;

    logic        clock;
    logic        resetn;
    logic        run;
    logic [15:0] current_instruction;
    logic [15:0] signflag;
    logic [15:0] zeroflag;
    logic [15:0] errorbit;
    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic [3:0]  alu_out_select;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;
    logic [3:0]  vga_color_select;
    logic [3:0]  vga_coord_select;
    logic        vga_plot;
    logic        halted;
    logic        illegal_op;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_count = 16'd0;

    control_unit #(.FETCH_WAIT(1), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .resetn(resetn), .run(run),
        .current_instruction(current_instruction),
        .signflag(signflag), .zeroflag(zeroflag), .errorbit(errorbit),
        .program_counter_increment(program_counter_increment),
        .alu_op(alu_op), .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
        .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
        .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
        .alu_out_select(alu_out_select), .alu_load_src(alu_load_src),
        .alu_store_to_mem(alu_store_to_mem), .alu_store_to_stk(alu_store_to_stk),
        .vga_color_select(vga_color_select), .vga_coord_select(vga_coord_select),
        .vga_plot(vga_plot), .halted(halted), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Start from IDLE or EXEC at a negedge; ends at the negedge inside the new EXEC.
    task automatic run_one(input logic [15:0] instr);
        current_instruction = instr;
        run = 1'b1;
        @(posedge clock);
        @(negedge clock);
        run = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        @(negedge clock);
        resetn = 1'b1;
        exp_count = 16'd0;
    endtask

    task automatic test_reset();
        run = 1'b1; current_instruction = 16'h7205;
        signflag = 16'h0; zeroflag = 16'h0; errorbit = 16'h0;
        resetn = 1'b0;
        #12;
        checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", instr_count); end
        checks++; if ({halted, illegal_op, program_counter_increment, vga_plot, alu_store_to_mem} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {halted, illegal_op, program_counter_increment, vga_plot, alu_store_to_mem}); end
        checks++; if ({alu_load_src, alu_out_select, alu_a_altern} !== 22'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", {alu_load_src, alu_out_select, alu_a_altern}); end
        run = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_ldi();
        run_one(16'h7205);
        checks++; if ({alu_a_source, alu_a_altern} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL ldi_a: got %b/%h expected 1/0005", alu_a_source, alu_a_altern); end
        checks++; if ({alu_out_select, alu_load_src, program_counter_increment, alu_op} !== {4'd2, 2'b01, 1'b1, 4'd0}) begin errors++; $display("FAIL ldi_ctrl: got out=%h ld=%b inc=%b op=%h expected 2/01/1/0", alu_out_select, alu_load_src, program_counter_increment, alu_op); end
        exp_count = exp_count + 16'd1;
        step();
        checks++; if ({alu_load_src, program_counter_increment} !== 3'b000) begin errors++; $display("FAIL ldi_after: got ld=%b inc=%b expected 00/0", alu_load_src, program_counter_increment); end
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL ldi_count: got %h expected %h", instr_count, exp_count); end
    endtask

    task automatic test_branches();
        run_one(16'h1123);
        checks++; if ({alu_op, alu_a_select, alu_b_select, alu_out_select, alu_load_src, program_counter_increment} !== {4'd1, 4'd2, 4'd3, 4'd1, 2'b01, 1'b1}) begin errors++; $display("FAIL add_ctrl: got op=%h a=%h b=%h out=%h ld=%b inc=%b", alu_op, alu_a_select, alu_b_select, alu_out_select, alu_load_src, program_counter_increment); end
        zeroflag = 16'h0001;
        run_one(16'hB040);
        zeroflag = 16'h0000;
        checks++; if ({alu_out_select, program_counter_increment, alu_a_select, alu_load_src} !== {4'd0, 1'b0, 4'd4, 2'b01}) begin errors++; $display("FAIL bz_taken: got out=%h inc=%b a=%h ld=%b expected 0/0/4/01", alu_out_select, program_counter_increment, alu_a_select, alu_load_src); end
        signflag = 16'h0001;
        run_one(16'h65FE);
        checks++; if ({alu_a_select, alu_b_source, alu_b_altern, alu_op, alu_out_select} !== {4'd5, 1'b1, 16'hFFFE, 4'd1, 4'd5}) begin errors++; $display("FAIL addi_ctrl: got a=%h bs=%b balt=%h op=%h out=%h", alu_a_select, alu_b_source, alu_b_altern, alu_op, alu_out_select); end
        run_one(16'hB040);
        signflag = 16'h0000;
        checks++; if ({alu_load_src, program_counter_increment} !== {2'b00, 1'b1}) begin errors++; $display("FAIL bz_not_taken: got ld=%b inc=%b expected 00/1", alu_load_src, program_counter_increment); end
        run_one(16'hC070);
        checks++; if ({alu_load_src, alu_a_select, program_counter_increment} !== {2'b01, 4'd7, 1'b0}) begin errors++; $display("FAIL bn_taken: got ld=%b a=%h inc=%b expected 01/7/0", alu_load_src, alu_a_select, program_counter_increment); end
        exp_count = exp_count + 16'd5;
        step();
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL branch_count: got %h expected %h", instr_count, exp_count); end
    endtask

    task automatic test_ld_st();
        run_one(16'h9370);
        checks++; if ({alu_store_to_mem, alu_out_select, alu_a_select, alu_load_src, program_counter_increment} !== {1'b1, 4'd3, 4'd7, 2'b00, 1'b1}) begin errors++; $display("FAIL st_ctrl: got st=%b out=%h a=%h ld=%b inc=%b", alu_store_to_mem, alu_out_select, alu_a_select, alu_load_src, program_counter_increment); end
        run_one(16'h8670);
        checks++; if ({alu_load_src, alu_out_select, alu_a_select, alu_store_to_mem} !== {2'b10, 4'd6, 4'd7, 1'b0}) begin errors++; $display("FAIL ld_ctrl: got ld=%b out=%h a=%h st=%b", alu_load_src, alu_out_select, alu_a_select, alu_store_to_mem); end
        run_one(16'h1012);
        checks++; if ({alu_out_select, alu_load_src, program_counter_increment} !== {4'd0, 2'b01, 1'b0}) begin errors++; $display("FAIL add_r0: got out=%h ld=%b inc=%b expected 0/01/0", alu_out_select, alu_load_src, program_counter_increment); end
        run_one(16'hA050);
        checks++; if ({alu_a_select, alu_out_select, alu_load_src, program_counter_increment} !== {4'd5, 4'd0, 2'b01, 1'b0}) begin errors++; $display("FAIL jmp_ctrl: got a=%h out=%h ld=%b inc=%b", alu_a_select, alu_out_select, alu_load_src, program_counter_increment); end
        run_one(16'hE340);
        checks++; if ({vga_color_select, vga_coord_select, vga_plot, program_counter_increment, alu_load_src} !== {4'd3, 4'd4, 1'b1, 1'b1, 2'b00}) begin errors++; $display("FAIL draw_ctrl: got c=%h xy=%h plot=%b inc=%b ld=%b", vga_color_select, vga_coord_select, vga_plot, program_counter_increment, alu_load_src); end
        exp_count = exp_count + 16'd5;
        step();
        checks++; if ({vga_plot, alu_store_to_stk} !== 2'b00) begin errors++; $display("FAIL draw_strobe: got plot=%b stk=%b expected 0/0", vga_plot, alu_store_to_stk); end
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL ldst_count: got %h expected %h", instr_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        current_instruction = 16'hE120;
        run = 1'b1;
        step();
        checks++; if (vga_plot !== 1'b0) begin errors++; $display("FAIL b2b_fetch1: got plot=%b expected 0", vga_plot); end
        step();
        checks++; if (vga_plot !== 1'b1) begin errors++; $display("FAIL b2b_exec1: got plot=%b expected 1", vga_plot); end
        current_instruction = 16'h0000;
        step();
        checks++; if ({vga_plot, program_counter_increment} !== 2'b00) begin errors++; $display("FAIL b2b_fetch2: got plot=%b inc=%b expected 0/0", vga_plot, program_counter_increment); end
        step();
        checks++; if ({program_counter_increment, alu_load_src} !== 3'b100) begin errors++; $display("FAIL b2b_nop: got inc=%b ld=%b expected 1/00", program_counter_increment, alu_load_src); end
        run = 1'b0;
        exp_count = exp_count + 16'd2;
        step();
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL b2b_count: got %h expected %h", instr_count, exp_count); end
    endtask

    task automatic test_halt();
        run_one(16'hF000);
        checks++; if ({program_counter_increment, alu_load_src, halted} !== 4'b0000) begin errors++; $display("FAIL halt_exec: got inc=%b ld=%b h=%b expected 0/00/0", program_counter_increment, alu_load_src, halted); end
        exp_count = exp_count + 16'd1;
        step();
        run = 1'b1; step(); run = 1'b0; step(); run = 1'b1; step();
        checks++; if ({halted, program_counter_increment, alu_load_src} !== 4'b1000) begin errors++; $display("FAIL halt_sticky: got h=%b inc=%b ld=%b expected 1/0/00", halted, program_counter_increment, alu_load_src); end
        checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL halt_count: got %h expected %h", instr_count, exp_count); end
        resetn = 1'b0;
        #1;
        checks++; if ({halted, instr_count} !== 17'h0) begin errors++; $display("FAIL halt_reset: got h=%b cnt=%h expected 0/0000", halted, instr_count); end
        run = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        exp_count = 16'd0;
        step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_idle: got h=%b expected 0", halted); end
    endtask

    task automatic test_illegal_and_error();
        run_one(16'hD000);
        checks++; if (program_counter_increment !== 1'b0) begin errors++; $display("FAIL illegal_exec: got inc=%b expected 0", program_counter_increment); end
        step();
        checks++; if ({halted, illegal_op, instr_count} !== {1'b1, 1'b1, 16'd1}) begin errors++; $display("FAIL illegal_halt: got h=%b ill=%b cnt=%h expected 1/1/0001", halted, illegal_op, instr_count); end
        do_reset();
        run_one(16'h1123);
        errorbit = 16'h0001;
        checks++; if ({alu_load_src, alu_out_select, program_counter_increment} !== {2'b01, 4'd1, 1'b1}) begin errors++; $display("FAIL err_commit: got ld=%b out=%h inc=%b expected 01/1/1", alu_load_src, alu_out_select, program_counter_increment); end
        step();
        errorbit = 16'h0000;
        checks++; if ({halted, illegal_op, instr_count} !== {1'b1, 1'b0, 16'd1}) begin errors++; $display("FAIL err_halt: got h=%b ill=%b cnt=%h expected 1/0/0001", halted, illegal_op, instr_count); end
        do_reset();
    endtask

    task automatic test_async_reset();
        run_one(16'h7205);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({alu_load_src, program_counter_increment, alu_a_source, alu_out_select} !== 8'h00) begin errors++; $display("FAIL async_reset: got ld=%b inc=%b as=%b out=%h expected 0", alu_load_src, program_counter_increment, alu_a_source, alu_out_select); end
        @(negedge clock);
        resetn = 1'b1;
        step();
        checks++; if ({instr_count, program_counter_increment} !== 17'h0) begin errors++; $display("FAIL async_after: got cnt=%h inc=%b expected 0000/0", instr_count, program_counter_increment); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_branches();
        test_ld_st();
        test_back_to_back();
        test_halt();
        test_illegal_and_error();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
